kamus_if: RTL

//  Instruction fetch stage: the producer end of the IF->ID interface. Generates sequential PCs,

---
 rtl/kamus_pkg.sv | 17 +
 rtl/kamus_imem_if.sv | 26 ++
 rtl/kamus_fetch_fifo.sv | 58 +++++
 rtl/kamus_if.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/kamus_pkg.sv
// Shared types and constants for the kamus instruction fetch stage.
package kamus_pkg;

   localparam int INSTR_BYTES = 4;

   typedef enum logic [1:0] {
      IF_IDLE,
      IF_FETCH,
      IF_FAULT
   } if_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/kamus_imem_if.sv
// Instruction-memory read bus: req/gnt address phase, in-order rvalid data phase.
interface kamus_imem_if #(
   parameter int PC_WIDTH = 32
);
   logic                req;
   logic [PC_WIDTH-1:0] addr;
   logic                gnt;
   logic                rvalid;
   logic [31:0]         rdata;

   modport master (
      output req,
      output addr,
      input  gnt,
      input  rvalid,
      input  rdata
   );

   modport slave (
      input  req,
      input  addr,
      output gnt,
      output rvalid,
      output rdata
   );
endinterface

// File: rtl/kamus_fetch_fifo.sv
// Synchronous prefetch FIFO of fetch entries; flush wins over push/pop.
module kamus_fetch_fifo
   import kamus_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         flush_i,
   input  logic         push_i,
   input  fetch_entry_t pushData_i,
   input  logic         pop_i,
   output fetch_entry_t headData_o,
   output logic         empty_o,
   output logic [CW-1:0] count_o
);

   fetch_entry_t  mem_q [DEPTH];
   logic [AW-1:0] rdPtr_q;
   logic [AW-1:0] wrPtr_q;
   logic [CW-1:0] count_q;
   logic          doPush;
   logic          doPop;

   assign doPop  = pop_i && (count_q != '0);
   assign doPush = push_i && ((count_q != CW'(DEPTH)) || doPop);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rdPtr_q <= '0;
         wrPtr_q <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (flush_i) begin
         rdPtr_q <= '0;
         wrPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (doPush) begin
            mem_q[wrPtr_q] <= pushData_i;
            wrPtr_q        <= wrPtr_q + AW'(1);
         end
         if (doPop) begin
            rdPtr_q <= rdPtr_q + AW'(1);
         end
         count_q <= count_q + CW'(doPush) - CW'(doPop);
      end
   end

   assign headData_o = mem_q[rdPtr_q];
   assign empty_o    = (count_q == '0);
   assign count_o    = count_q;

endmodule

// File: rtl/kamus_if.sv
// Instruction fetch stage: issues sequential word reads, buffers responses, hands {instr, pc} to ID.
// Optional misaligned-redirect fault state and fault_o port under KAMUS_IF_MISALIGN_CHECK_EN.
module kamus_if
   import kamus_pkg::*;
#(
   parameter int                  PC_WIDTH        = 32,
   parameter logic [PC_WIDTH-1:0] BOOT_ADDR       = '0,
   parameter int                  FIFO_DEPTH      = 4,
   parameter int                  MAX_OUTSTANDING = 2
) (
   input  logic                clk_i,
   input  logic                rst_i,
   kamus_imem_if.master        imem,
   input  logic                redirect_i,
   input  logic [PC_WIDTH-1:0] redirect_pc_i,
   output logic                instr_valid_o,
   input  logic                instr_ready_i,
   output logic [31:0]         instr_o,
   output logic [PC_WIDTH-1:0] pc_o
`ifdef KAMUS_IF_MISALIGN_CHECK_EN
   ,
   output logic                fault_o
`endif
);

   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   if_state_e           state_q, state_d;
   logic [PC_WIDTH-1:0] fetchPc_q, fetchPc_d;
   logic [PC_WIDTH-1:0] rspPc_q, rspPc_d;
   logic [OW-1:0]       outstanding_q, outstanding_d;
   logic [OW-1:0]       discard_q, discard_d;

   logic                credit;
   logic                issue;
   logic                granted;
   logic                respValid;
   logic                push;
   logic                pop;
   logic                misaligned;
   logic [PC_WIDTH-1:0] targetPc;
   logic [CW-1:0]       fifoCount;
   logic                fifoEmpty;
   fetch_entry_t        head;

`ifdef KAMUS_IF_MISALIGN_CHECK_EN
   assign targetPc   = redirect_pc_i;
   assign misaligned = (redirect_pc_i[1:0] != 2'b00);
`else
   assign targetPc   = redirect_pc_i & ~PC_WIDTH'(3);
   assign misaligned = 1'b0;
`endif

   // Reserve a FIFO slot for every request in flight so a response can never meet a full FIFO.
   assign credit    = (int'(outstanding_q) + int'(fifoCount) < FIFO_DEPTH)
                      && (int'(outstanding_q) < MAX_OUTSTANDING);
   assign issue     = (state_q == IF_FETCH) && credit;
   assign granted   = issue && imem.gnt;
   assign respValid = imem.rvalid && (outstanding_q != '0);

   assign outstanding_d = outstanding_q + OW'(granted) - OW'(respValid);
   assign push          = respValid && (discard_q == '0) && !redirect_i;
   assign pop           = instr_valid_o && instr_ready_i && !redirect_i;

   assign imem.req  = issue;
   assign imem.addr = fetchPc_q;

   always_comb begin
      state_d   = state_q;
      fetchPc_d = fetchPc_q;
      rspPc_d   = rspPc_q;
      discard_d = discard_q;
      unique case (state_q)
         IF_IDLE:  state_d = IF_FETCH;
         IF_FETCH: state_d = IF_FETCH;
         IF_FAULT: state_d = IF_FAULT;
         default:  state_d = IF_IDLE;
      endcase
      if (granted) begin
         fetchPc_d = fetchPc_q + PC_WIDTH'(INSTR_BYTES);
      end
      if (push) begin
         rspPc_d = rspPc_q + PC_WIDTH'(INSTR_BYTES);
      end
      if (respValid && (discard_q != '0)) begin
         discard_d = discard_q - OW'(1);
      end
      // Everything still in flight after this cycle belongs to the abandoned stream.
      if (redirect_i) begin
         fetchPc_d = targetPc;
         rspPc_d   = targetPc;
         discard_d = outstanding_d;
         state_d   = misaligned ? IF_FAULT : IF_FETCH;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q       <= IF_IDLE;
         fetchPc_q     <= BOOT_ADDR;
         rspPc_q       <= BOOT_ADDR;
         outstanding_q <= '0;
         discard_q     <= '0;
      end else begin
         state_q       <= state_d;
         fetchPc_q     <= fetchPc_d;
         rspPc_q       <= rspPc_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
      end
   end

   kamus_fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .flush_i    (redirect_i),
      .push_i     (push),
      .pushData_i ('{pc: 32'(rspPc_q), instr: imem.rdata}),
      .pop_i      (pop),
      .headData_o (head),
      .empty_o    (fifoEmpty),
      .count_o    (fifoCount)
   );

   assign instr_valid_o = !fifoEmpty;
   assign instr_o       = head.instr;

`ifdef KAMUS_IF_MISALIGN_CHECK_EN
   assign pc_o    = (state_q == IF_FAULT) ? fetchPc_q : PC_WIDTH'(head.pc);
   assign fault_o = (state_q == IF_FAULT);
`else
   assign pc_o    = PC_WIDTH'(head.pc);
`endif

   rvalidNeedsOutstanding: assert property (
      @(posedge clk_i) disable iff (rst_i) !(imem.rvalid && (outstanding_q == '0))
   );

endmodule
